// File: rtl/bec_pkg.sv
// Shared constants and types for the pipelined binary-to-excess-1 converter.
package bec_pkg;

  localparam int unsigned BEC_MAX_WIDTH = 64;
  localparam int unsigned BEC_SPLIT_DEN = 2;

  typedef enum logic {
    BEC_INC = 1'b0,
    BEC_DEC = 1'b1
  } bec_mode_e;

endpackage

// File: rtl/bec_core.sv
// Combinational excess-1 slice: y = x +/- cin, with the prefix flag chained across slices.
module bec_core
  import bec_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  bec_mode_e        mode,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             wrap
);

  logic [WIDTH:0]   pre;
  logic [WIDTH-1:0] t;

  // Decrement propagates through zeros, increment through ones.
  always_comb begin
    t      = (mode == BEC_DEC) ? ~x : x;
    pre    = '0;
    pre[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pre[i+1] = pre[i] & t[i];
    end
    y    = x ^ pre[WIDTH-1:0];
    wrap = pre[WIDTH];
  end

endmodule

// File: rtl/bec_pipe.sv
// Pipelined BEC-1 with valid/ready handshake; 1 or 2 stages.
// Decrement mode and the in_dec port exist only when BEC_DEC_EN is defined.
module bec_pipe
  import bec_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef BEC_DEC_EN
  input  logic             in_dec,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_wrap
);

  if (WIDTH < 2 || WIDTH > BEC_MAX_WIDTH) begin : g_bad_width
    $error("bec_pipe: WIDTH must be within 2..64");
  end
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("bec_pipe: STAGES must be 1 or 2");
  end

  bec_mode_e in_mode;
`ifdef BEC_DEC_EN
  assign in_mode = in_dec ? BEC_DEC : BEC_INC;
`else
  assign in_mode = BEC_INC;
`endif

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_wrap_q;
  logic             out_load;

  // Payload offered to the output register by the preceding logic.
  logic             st_valid;
  logic [WIDTH-1:0] st_y;
  logic             st_wrap;

  assign out_load = ~out_valid_q | out_ready;

  if (STAGES == 1) begin : g_one
    bec_core #(
      .WIDTH(WIDTH)
    ) u_core (
      .x   (in_data),
      .mode(in_mode),
      .cin (1'b1),
      .y   (st_y),
      .wrap(st_wrap)
    );

    assign st_valid = in_valid;
    assign in_ready = out_load;
  end else begin : g_two
    localparam int unsigned L = WIDTH / BEC_SPLIT_DEN;
    localparam int unsigned H = WIDTH - L;

    logic             v1_q;
    logic [WIDTH-1:0] x1_q;
    logic             p1_q;
    bec_mode_e        mode1;
    logic [L-1:0]     lo_t;
    logic [L-1:0]     y_lo;
    logic [H-1:0]     y_hi;
    logic             lo_wrap_unused;

    assign lo_t     = (in_mode == BEC_DEC) ? ~in_data[L-1:0] : in_data[L-1:0];
    assign in_ready = ~v1_q | out_load;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v1_q <= 1'b0;
        x1_q <= '0;
        p1_q <= 1'b0;
      end else if (in_ready) begin
        v1_q <= in_valid;
        if (in_valid) begin
          x1_q <= in_data;
          p1_q <= &lo_t;
        end
      end
    end

`ifdef BEC_DEC_EN
    bec_mode_e mode1_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode1_q <= BEC_INC;
      end else if (in_ready && in_valid) begin
        mode1_q <= in_mode;
      end
    end
    assign mode1 = mode1_q;
`else
    assign mode1 = BEC_INC;
`endif

    bec_core #(
      .WIDTH(L)
    ) u_core_lo (
      .x   (x1_q[L-1:0]),
      .mode(mode1),
      .cin (1'b1),
      .y   (y_lo),
      .wrap(lo_wrap_unused)
    );

    // Upper half starts from the registered low-half prefix, not the low core's wrap.
    bec_core #(
      .WIDTH(H)
    ) u_core_hi (
      .x   (x1_q[WIDTH-1:L]),
      .mode(mode1),
      .cin (p1_q),
      .y   (y_hi),
      .wrap(st_wrap)
    );

    assign st_valid = v1_q;
    assign st_y     = {y_hi, y_lo};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_wrap_q  <= 1'b0;
    end else if (out_load) begin
      out_valid_q <= st_valid;
      if (st_valid) begin
        out_data_q <= st_y;
        out_wrap_q <= st_wrap;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_wrap  = out_wrap_q;

endmodule

// File: tb/tb_bec_pipe.sv
// Directed and scoreboarded checks of bec_pipe across several width/depth configurations.
module tb_bec_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // a: WIDTH=8 STAGES=2, b: WIDTH=4 STAGES=1, c: WIDTH=16 STAGES=2, d: WIDTH=37 STAGES=2
  logic        a_valid = 0, a_in_ready, a_out_valid, a_ready = 1, a_wrap;
  logic [7:0]  a_data = 0, a_out;
  logic        b_valid = 0, b_in_ready, b_out_valid, b_ready = 1, b_wrap;
  logic [3:0]  b_data = 0, b_out;
  logic        c_valid = 0, c_in_ready, c_out_valid, c_ready = 1, c_wrap;
  logic [15:0] c_data = 0, c_out;
  logic        d_valid = 0, d_in_ready, d_out_valid, d_ready = 1, d_wrap;
  logic [36:0] d_data = 0, d_out;
  logic        a_dec = 0, b_dec = 0, c_dec = 0, d_dec = 0;

  bec_pipe #(.WIDTH(8), .STAGES(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_in_ready), .in_data(a_data),
`ifdef BEC_DEC_EN
    .in_dec(a_dec),
`endif
    .out_valid(a_out_valid), .out_ready(a_ready), .out_data(a_out), .out_wrap(a_wrap)
  );

  bec_pipe #(.WIDTH(4), .STAGES(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_in_ready), .in_data(b_data),
`ifdef BEC_DEC_EN
    .in_dec(b_dec),
`endif
    .out_valid(b_out_valid), .out_ready(b_ready), .out_data(b_out), .out_wrap(b_wrap)
  );

  bec_pipe #(.WIDTH(16), .STAGES(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_in_ready), .in_data(c_data),
`ifdef BEC_DEC_EN
    .in_dec(c_dec),
`endif
    .out_valid(c_out_valid), .out_ready(c_ready), .out_data(c_out), .out_wrap(c_wrap)
  );

  bec_pipe #(.WIDTH(37), .STAGES(2)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_valid), .in_ready(d_in_ready), .in_data(d_data),
`ifdef BEC_DEC_EN
    .in_dec(d_dec),
`endif
    .out_valid(d_out_valid), .out_ready(d_ready), .out_data(d_out), .out_wrap(d_wrap)
  );

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out, a_wrap, a_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_a got v=%0b d=%h w=%0b rdy=%0b want v=0 d=00 w=0 rdy=1",
               a_out_valid, a_out, a_wrap, a_in_ready);
    end
    n_cmp++;
    if ({b_out_valid, b_out, b_wrap, b_in_ready} !== {1'b0, 4'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_b got v=%0b d=%h w=%0b rdy=%0b want v=0 d=0 w=0 rdy=1",
               b_out_valid, b_out, b_wrap, b_in_ready);
    end
    n_cmp++;
    if ({c_out_valid, c_in_ready, d_out_valid, d_in_ready, d_out} !== {4'b0101, 37'd0}) begin
      n_err++;
      $display("FAIL reset_cd got cv=%0b crdy=%0b dv=%0b drdy=%0b dd=%h want 0 1 0 1 0",
               c_out_valid, c_in_ready, d_out_valid, d_in_ready, d_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_inc8();
    a_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 8'h0F;
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL inc8_latency out_valid got %0b want 0", a_out_valid);
    end
    a_data = 8'hFF;
    @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out, a_wrap} !== {1'b1, 8'h10, 1'b0}) begin
      n_err++;
      $display("FAIL inc8_0f got v=%0b d=%h w=%0b want v=1 d=10 w=0", a_out_valid, a_out, a_wrap);
    end
    a_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out, a_wrap} !== {1'b1, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL inc8_ff got v=%0b d=%h w=%0b want v=1 d=00 w=1", a_out_valid, a_out, a_wrap);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL inc8_drain out_valid got %0b want 0", a_out_valid);
    end
  endtask

  task automatic test_stream4();
    logic [3:0] ed;
    b_ready = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      ed = 4'(i);
      if (i >= 1 && i <= 16) begin
        n_cmp++;
        if ({b_out_valid, b_out, b_wrap} !== {1'b1, ed, (i == 16)}) begin
          n_err++;
          $display("FAIL stream4_%0d got v=%0b d=%h w=%0b want v=1 d=%h w=%0b",
                   i, b_out_valid, b_out, b_wrap, ed, (i == 16));
        end
      end
      if (i == 17) begin
        n_cmp++;
        if (b_out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stream4_drain out_valid got %0b want 0", b_out_valid);
        end
      end
      if (i < 16) begin
        b_valid = 1'b1;
        b_data  = 4'(i);
        #1;
        n_cmp++;
        if (b_in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL stream4_ready_%0d got %0b want 1", i, b_in_ready);
        end
      end else begin
        b_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_ready = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'h12;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready0 got %0b want 1", a_in_ready);
    end
    @(negedge clk);
    a_data = 8'h34;
    n_cmp++;
    if (a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready1 got %0b want 1", a_in_ready);
    end
    @(negedge clk);
    a_data = 8'h56;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if ({a_in_ready, a_out_valid, a_out, a_wrap} !== {2'b01, 8'h13, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold_%0d got rdy=%0b v=%0b d=%h w=%0b want rdy=0 v=1 d=13 w=0",
                 k, a_in_ready, a_out_valid, a_out, a_wrap);
      end
    end
    @(negedge clk);
    a_ready = 1'b1;
    #1;
    n_cmp++;
    if ({a_in_ready, a_out} !== {1'b1, 8'h13}) begin
      n_err++;
      $display("FAIL bp_release got rdy=%0b d=%h want rdy=1 d=13", a_in_ready, a_out);
    end
    @(negedge clk);
    a_valid = 1'b0;
    n_cmp++;
    if ({a_out_valid, a_out} !== {1'b1, 8'h35}) begin
      n_err++;
      $display("FAIL bp_second got v=%0b d=%h want v=1 d=35", a_out_valid, a_out);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out} !== {1'b1, 8'h57}) begin
      n_err++;
      $display("FAIL bp_third got v=%0b d=%h want v=1 d=57", a_out_valid, a_out);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain out_valid got %0b want 0", a_out_valid);
    end
  endtask

  task automatic test_w16();
    logic [15:0] vx[7] = '{16'hFFFF, 16'h7FFF, 16'h00FF, 16'h1234, 16'h0000, 16'h8000, 16'h0100};
    logic        vd[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] vy[7] = '{16'h0000, 16'h8000, 16'h0100, 16'h1235, 16'hFFFF, 16'h7FFF, 16'h00FF};
    logic        vw[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef BEC_DEC_EN
    int nv = 7;
`else
    int nv = 4;
`endif
    c_ready = 1'b1;
    for (int i = 0; i < nv + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_cmp++;
        if ({c_out_valid, c_out, c_wrap} !== {1'b1, vy[i-2], vw[i-2]}) begin
          n_err++;
          $display("FAIL w16_%0d x=%h dec=%0b got v=%0b d=%h w=%0b want v=1 d=%h w=%0b",
                   i - 2, vx[i-2], vd[i-2], c_out_valid, c_out, c_wrap, vy[i-2], vw[i-2]);
        end
      end
      if (i < nv) begin
        c_valid = 1'b1;
        c_data  = vx[i];
        c_dec   = vd[i];
      end else begin
        c_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_flight();
    a_ready = 1'b0;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 8'h21;
    @(negedge clk);
    a_data = 8'h22;
    @(negedge clk);
    a_valid = 1'b0;
    rst     = 1'b1;
    #1;
    n_cmp++;
    if ({a_out_valid, a_out, a_in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL rst_flight got v=%0b d=%h rdy=%0b want v=0 d=00 rdy=1",
               a_out_valid, a_out, a_in_ready);
    end
    @(negedge clk);
    rst     = 1'b0;
    a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_out_valid, a_in_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL rst_stale_%0d got v=%0b rdy=%0b want v=0 rdy=1", k, a_out_valid, a_in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [37:0] q[$];
    logic [37:0] exp;
    logic [63:0] r;
    logic [36:0] x;
    logic        held;
    logic [37:0] held_val;
    int          sent = 0;
    held = 1'b0;
    held_val = '0;
    for (int cyc = 0; cyc < 60000 && (sent < 10000 || q.size() > 0); cyc++) begin
      @(negedge clk);
      if (held) begin
        n_cmp++;
        if ({d_out_valid, d_wrap, d_out} !== {1'b1, held_val}) begin
          n_err++;
          $display("FAIL rnd_hold cyc=%0d got v=%0b %h want v=1 %h",
                   cyc, d_out_valid, {d_wrap, d_out}, held_val);
        end
      end
      r = {$urandom(), $urandom()};
      x = r[36:0];
      if (cyc % 40 == 7) x = '1;
      if (cyc % 40 == 23) x = '0;
      d_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      d_data  = x;
`ifdef BEC_DEC_EN
      d_dec = 1'($urandom_range(0, 1));
`else
      d_dec = 1'b0;
`endif
      d_ready = (sent >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      held     = d_out_valid && !d_ready;
      held_val = {d_wrap, d_out};
      if (d_out_valid && d_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_extra cyc=%0d got %h want nothing", cyc, {d_wrap, d_out});
        end else begin
          exp = q.pop_front();
          if ({d_wrap, d_out} !== exp) begin
            n_err++;
            $display("FAIL rnd_data cyc=%0d got w=%0b d=%h want w=%0b d=%h",
                     cyc, d_wrap, d_out, exp[37], exp[36:0]);
          end
        end
      end
      if (d_valid && d_in_ready) begin
        if (d_dec) exp = {(x == 37'd0), x - 37'd1};
        else exp = {(x == {37{1'b1}}), x + 37'd1};
        q.push_back(exp);
        sent++;
      end
    end
    d_valid = 1'b0;
    n_cmp++;
    if (sent != 10000 || q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_timeout got sent=%0d pending=%0d want sent=10000 pending=0",
               sent, q.size());
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_inc8();
    test_stream4();
    test_backpressure();
    test_w16();
    test_reset_flight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bec_pipe.md
# bec_pipe

Parametrised, pipelined binary-to-excess-1 converter (BEC-1) with valid/ready handshaking. It replaces fixed-width 4–8 bit BEC instances wherever the result feeds registered logic, such as carry-select adder select paths and recursive multiplier partial-sum stages. Width and pipeline depth are generic. The block also reports a wrap flag, and decrement mode is optional.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; legal range 2..64.
- STAGES, 2: pipeline depth; legal values 1 or 2. Any other value is an elaboration error.

Ports:
- clk  input  1  clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  operand x.
- in_dec  input  1  1 selects x-1, 0 selects x+1. Present only when BEC_DEC_EN is defined.
- out_valid  output  1  out_data and out_wrap are valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  result y.
- out_wrap  output  1  set when the operation wrapped (carry-out or borrow-out).

## Operation
- Increment: y = (x + 1) mod 2^WIDTH.
  - y[0] = ~x[0].
  - y[i] = x[i] ^ (x[i-1] & … & x[0]).
  - out_wrap = &x.
- Decrement (BEC_DEC_EN only): y = (x − 1) mod 2^WIDTH.
  - y[i] = x[i] ^ (~x[i-1] & … & ~x[0]).
  - out_wrap = ~|x.
- STAGES=2 splits the prefix AND chain at L = WIDTH/2 (floor):
  - Stage 1 registers x, the mode, and the low-half prefix flag p = &x[L-1:0] (or ~|x[L-1:0] in decrement mode).
  - Stage 2 computes the upper half using p combined with the upper-half prefix, then registers y and out_wrap.
- STAGES=1: y and out_wrap are computed combinationally from in_data and registered once.
- Each stage holds a valid bit and a payload.
  - A stage loads when it is empty or when its contents are leaving in the same cycle.
  - in_ready = ~v1 | (stage 1 advances this cycle).
  - With STAGES=2, stage 1 advances when ~v2 | out_ready.
  - The last stage is cleared when out_ready=1 and no new data arrives.
- A transfer occurs when valid & ready are both high at the rising edge of clk.
- out_data and out_wrap hold steady while out_valid=1 and out_ready=0.

## Timing
- Reset values: all stage valid bits 0, out_valid=0, out_data=0, out_wrap=0, in_ready=1. Reset takes effect asynchronously and is released synchronously by the driver.
- Reset asserted mid-operation discards all in-flight operands; nothing partial is emitted afterwards.
- Latency: an operand accepted in cycle n appears with out_valid=1 in cycle n+STAGES.
- Throughput: one operation per cycle while out_ready=1.
- Backpressure: with out_ready held at 0 the pipe absorbs exactly STAGES operands, then in_ready=0.
- Combinational paths:
  - in_ready depends combinationally on out_ready.
  - out_data does not depend on any input in the same cycle.
- Simultaneous accept and emit on a full pipe is lossless and keeps order.
- Critical path for STAGES=2: a ceil(WIDTH/2)-input AND gate followed by an XOR.

## Configuration
- Macro BEC_DEC_EN.
- Defined:
  - The in_dec port exists and is registered alongside the data in every stage.
  - Decrement mode is available as described under Operation.
- Undefined:
  - The in_dec port is absent.
  - The block always increments.
  - No mode register is instantiated.

## Structure
- Package bec_pkg holds:
  - constants BEC_MAX_WIDTH=64 and BEC_SPLIT_DEN=2;
  - typedef bec_mode_e {BEC_INC, BEC_DEC}.
- Sub-module bec_core: combinational and parametrised on WIDTH. It takes x, mode and a carry-in prefix flag and returns y and the wrap flag. Stage 2 instantiates it once for the upper half and once for the lower half.

## Test plan
- WIDTH=8, STAGES=2, out_ready=1: input 0x0F → 0x10 with out_wrap=0, appearing 2 cycles later; input 0xFF → 0x00 with out_wrap=1.
- WIDTH=4, STAGES=1: a back-to-back stream 0x0..0xF → outputs 0x1..0xF then 0x0, one per cycle, with out_wrap=1 only for the last.
- Backpressure: out_ready=0 after 2 accepts → in_ready=0. Release out_ready → both results emerge in order and unchanged.
- BEC_DEC_EN, WIDTH=16: 0x0000 with dec → 0xFFFF and out_wrap=1; 0x8000 with dec → 0x7FFF and out_wrap=0.
- Reset asserted with 2 operands in flight → out_valid=0 immediately; after release, no stale output appears and in_ready=1.
- Random: 10k operands at WIDTH=37 with random in_valid/out_ready → every result matches (x±1) mod 2^37 and arrives in order.
